// File: rtl/bb_play_tx_if.sv
// Stream interface for bb_play_tx: upstream action handshake plus the
// game stream driven towards the scoreboard.
interface bb_play_tx_if;
   logic       act_valid;
   logic [2:0] act_data;
   logic       act_ready;
   logic       in_valid;
   logic [1:0] inning;
   logic       half;
   logic [2:0] action;

   // master: the transmitter; slave: producer + scoreboard side
   modport master (
      input  act_valid, act_data,
      output act_ready, in_valid, inning, half, action
   );
   modport slave (
      output act_valid, act_data,
      input  act_ready, in_valid, inning, half, action
   );
endinterface

// File: rtl/bb_play_tx.sv
// Scoreboard action-stream transmitter: buffers action codes in a FIFO and
// replays them as one gap-free game burst, tracking outs and the runner on 1st.
module bb_play_tx #(
   parameter int DEPTH   = 16,
   parameter int PRELOAD = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   bb_play_tx_if.master bus,
   output logic         busy,
   output logic         game_done,
   output logic         underrun
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, FILL, SEND, ENDG} state_t;

   state_t state, next_state;

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop, full, empty, fill_ok, send_entry;
   logic [2:0]    head;

   logic [1:0] outs, outs_nxt;
   logic       first_occ, first_nxt;
   logic [1:0] cur_inning;
   logic       cur_half;
   logic       third_out, game_over;

   logic       in_valid_q, half_q;
   logic [1:0] inning_q;
   logic [2:0] action_q;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push    = bus.act_valid && !full;
   assign head    = mem[rd_ptr];
   assign fill_ok = (count + CW'(push)) >= CW'(PRELOAD);

   assign bus.act_ready = !full;
   assign bus.in_valid  = in_valid_q;
   assign bus.inning    = inning_q;
   assign bus.half      = half_q;
   assign bus.action    = action_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage array is not reset; only pointers/count define validity,
   // which keeps it mappable onto RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.act_data;
   end

   // Outs/base update implied by the action at the FIFO head.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      outs_nxt  = outs;
      first_nxt = first_occ;
      case (head)
         3'd0, 3'd1:       first_nxt = 1'b1;
         3'd2, 3'd3, 3'd4: first_nxt = 1'b0;
         3'd5: begin
            outs_nxt  = outs + 2'd1;
            first_nxt = 1'b0;
         end
         3'd6: begin
            outs_nxt  = (first_occ && outs < 2'd2) ? outs + 2'd2 : outs + 2'd1;
            first_nxt = 1'b0;
         end
         default:          outs_nxt = outs + 2'd1;
      endcase
   end

   assign third_out = (outs_nxt == 2'd3);
   assign game_over = third_out && (cur_inning == 2'd3) && cur_half;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start)   next_state = FILL;
         FILL: if (fill_ok) next_state = SEND;
         SEND: begin
            if (empty)          next_state = IDLE;
            else if (game_over) next_state = ENDG;
         end
         default:           next_state = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != IDLE);
      pop        = (state == SEND) && !empty;
      send_entry = (state == FILL) && fill_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_valid_q <= 1'b0;
         inning_q   <= '0;
         half_q     <= 1'b0;
         action_q   <= '0;
         game_done  <= 1'b0;
         underrun   <= 1'b0;
         cur_inning <= '0;
         cur_half   <= 1'b0;
         outs       <= '0;
         first_occ  <= 1'b0;
      end else begin
         in_valid_q <= pop;
         game_done  <= (state == ENDG);
         underrun   <= (state == SEND) && empty;
         if (send_entry) begin
            cur_inning <= 2'd1;
            cur_half   <= 1'b0;
            inning_q   <= 2'd1;
            half_q     <= 1'b0;
            outs       <= '0;
            first_occ  <= 1'b0;
         end
         if (pop) begin
            action_q <= head;
            inning_q <= cur_inning;
            half_q   <= cur_half;
            // Third out: the following beat carries the advanced half/inning
            if (third_out) begin
               outs      <= '0;
               first_occ <= 1'b0;
               if (!cur_half) begin
                  cur_half <= 1'b1;
               end else if (!game_over) begin
                  cur_half   <= 1'b0;
                  cur_inning <= cur_inning + 2'd1;
               end
            end else begin
               outs      <= outs_nxt;
               first_occ <= first_nxt;
            end
         end
      end
   end

endmodule
